// File: rtl/branch_resolve_mp.sv
// Multi-port branch resolution: per-port target/mispredict/exception logic, one
// registered resolve stage, and an in-order resolution queue towards the frontend.
module branch_resolve_mp #(
    parameter int unsigned NrPorts = 2,
    parameter int unsigned Depth   = 4,
    parameter int unsigned VLEN    = 64,
    parameter bit          RVC     = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    output logic                    ready_o,
    input  logic [NrPorts-1:0]      valid_i,
    input  logic [NrPorts*2-1:0]    op_i,
    input  logic [NrPorts*VLEN-1:0] pc_i,
    input  logic [NrPorts-1:0]      is_compressed_i,
    input  logic [NrPorts*VLEN-1:0] operand_a_i,
    input  logic [NrPorts*VLEN-1:0] imm_i,
    input  logic [NrPorts-1:0]      comp_res_i,
    input  logic [NrPorts*3-1:0]    pred_cf_i,
    input  logic [NrPorts*VLEN-1:0] pred_addr_i,
    output logic [NrPorts-1:0]      result_valid_o,
    output logic [NrPorts*VLEN-1:0] result_o,
    output logic [NrPorts-1:0]      exc_valid_o,
    output logic [NrPorts*VLEN-1:0] exc_tval_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [VLEN-1:0]         res_pc_o,
    output logic [VLEN-1:0]         res_target_o,
    output logic                    res_taken_o,
    output logic                    res_mispredict_o,
    output logic [2:0]              res_cf_o,
    output logic [$clog2(Depth):0]  count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    localparam logic [1:0] OpBr   = 2'b00;
    localparam logic [1:0] OpJal  = 2'b01;
    localparam logic [1:0] OpJalr = 2'b10;
    localparam logic [1:0] OpRsv  = 2'b11;

    localparam logic [2:0] CfNo  = 3'd0;
    localparam logic [2:0] CfBr  = 3'd1;
    localparam logic [2:0] CfJr  = 3'd3;
    localparam logic [2:0] CfRet = 3'd4;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic            mispredict;
        logic [2:0]      cf;
    } entry_t;

    function automatic logic [PtrW-1:0] wrap_ptr(input int unsigned v);
        return PtrW'(v % Depth);
    endfunction

    logic [VLEN-1:0] pc_w     [NrPorts];
    logic [VLEN-1:0] nxt_pc   [NrPorts];
    logic [VLEN-1:0] tgt      [NrPorts];
    logic [VLEN-1:0] actual   [NrPorts];
    logic [2:0]      cf       [NrPorts];
    logic [NrPorts-1:0] taken, misp, exc, real_op;

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        logic [1:0]      op_w;
        logic [2:0]      pcf_w;
        logic [VLEN-1:0] base_w, sum_w;

        assign op_w      = op_i[2*p +: 2];
        assign pcf_w     = pred_cf_i[3*p +: 3];
        assign pc_w[p]   = pc_i[p*VLEN +: VLEN];
        assign nxt_pc[p] = pc_w[p] + (is_compressed_i[p] ? VLEN'(2) : VLEN'(4));
        assign base_w    = (op_w == OpJalr) ? operand_a_i[p*VLEN +: VLEN] : pc_w[p];
        assign sum_w     = base_w + imm_i[p*VLEN +: VLEN];
        assign tgt[p]    = (op_w == OpJalr) ? {sum_w[VLEN-1:1], 1'b0} : sum_w;
        assign taken[p]  = (op_w == OpJal || op_w == OpJalr) ? 1'b1 : comp_res_i[p];
        assign actual[p] = taken[p] ? tgt[p] : nxt_pc[p];
        assign misp[p]   = (op_w == OpBr)   ? (comp_res_i[p] != (pcf_w == CfBr)) :
                           (op_w == OpJalr) ? ((pcf_w == CfNo) || (tgt[p] != pred_addr_i[p*VLEN +: VLEN])) :
                           1'b0;
        // A mispredicted return stays a return so the RAS update is not lost.
        assign cf[p]     = (op_w == OpBr) ? CfBr :
                           (op_w == OpJalr && misp[p] && pcf_w != CfRet) ? CfJr : pcf_w;
        assign exc[p]    = taken[p] & (tgt[p][0] | (RVC ? 1'b0 : tgt[p][1]));
        assign real_op[p] = valid_i[p] & (op_w != OpRsv);
    end

    logic accept, kill;
    logic [NrPorts-1:0] live;
    logic [NrPorts-1:0] vld_d, exc_d, enq_d;
    logic [NrPorts-1:0][VLEN-1:0] res_d, tval_d;
    entry_t [NrPorts-1:0] ent_d;

    assign accept = ready_o & ~flush_i;

    // Squash: the oldest redirecting op kills every younger port this cycle.
    always_comb begin
        kill  = 1'b0;
        live  = '0;
        vld_d = '0;
        exc_d = '0;
        enq_d = '0;
        res_d = '0;
        tval_d = '0;
        ent_d = '0;
        for (int p = 0; p < NrPorts; p++) begin
            live[p] = real_op[p] & accept & ~kill;
            if (live[p] && (misp[p] || exc[p])) kill = 1'b1;
            vld_d[p]  = live[p];
            res_d[p]  = live[p] ? nxt_pc[p] : '0;
            exc_d[p]  = live[p] & exc[p];
            tval_d[p] = (live[p] & exc[p]) ? pc_w[p] : '0;
            enq_d[p]  = live[p] & ~exc[p];
            ent_d[p]  = (live[p] & ~exc[p]) ? {pc_w[p], actual[p], taken[p], misp[p], cf[p]} : '0;
        end
    end

    // ---- resolve stage register (p1) ----
    logic [NrPorts-1:0] vld_p1_q, exc_p1_q, enq_p1_q;
    logic [NrPorts-1:0][VLEN-1:0] res_p1_q, tval_p1_q;
    entry_t [NrPorts-1:0] ent_p1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1_q  <= '0;
            exc_p1_q  <= '0;
            enq_p1_q  <= '0;
            res_p1_q  <= '0;
            tval_p1_q <= '0;
            ent_p1_q  <= '0;
        end else begin
            vld_p1_q  <= vld_d;
            exc_p1_q  <= exc_d;
            enq_p1_q  <= enq_d;
            res_p1_q  <= res_d;
            tval_p1_q <= tval_d;
            ent_p1_q  <= ent_d;
        end
    end

    assign result_valid_o = vld_p1_q;
    assign result_o       = res_p1_q;
    assign exc_valid_o    = exc_p1_q;
    assign exc_tval_o     = tval_p1_q;

    // ---- resolution queue ----
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_idx [NrPorts];
    int unsigned     push_cnt;
    logic            pop;
    entry_t          mem_q [Depth];
    entry_t          head_ent;

    always_comb begin
        push_cnt = 0;
        for (int p = 0; p < NrPorts; p++) begin
            wr_idx[p] = wrap_ptr(32'(tail_q) + push_cnt);
            if (enq_p1_q[p]) push_cnt = push_cnt + 1;
        end
    end

    assign pop     = res_valid_o & res_ready_i;
    assign head_d  = pop ? wrap_ptr(32'(head_q) + 1) : head_q;
    assign tail_d  = wrap_ptr(32'(tail_q) + push_cnt);
    assign count_d = CntW'(32'(count_q) + push_cnt - 32'(pop));

    // Entries still in the stage register are counted so a full burst always fits.
    assign ready_o = (int'(Depth) - int'(count_q) - int'(push_cnt)) >= int'(NrPorts);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NrPorts; p++) begin
            if (enq_p1_q[p]) mem_q[wr_idx[p]] <= ent_p1_q[p];
        end
    end

    assign head_ent         = mem_q[head_q];
    assign res_valid_o      = (count_q != '0);
    assign res_pc_o         = res_valid_o ? head_ent.pc : '0;
    assign res_target_o     = res_valid_o ? head_ent.target : '0;
    assign res_taken_o      = res_valid_o & head_ent.taken;
    assign res_mispredict_o = res_valid_o & head_ent.mispredict;
    assign res_cf_o         = res_valid_o ? head_ent.cf : '0;
    assign count_o          = count_q;

    // Issuing while not ready is a protocol error; a flush drops inputs anyway.
    assert property (@(posedge clk_i) disable iff (rst_i || flush_i) !((|valid_i) && !ready_o));

endmodule

// File: tb/tb_branch_resolve_mp.sv
// Directed bench for branch_resolve_mp: queue-level behavioural model checked every
// cycle, plus literal expectations on a second instance built with RVC=0.
module tb_branch_resolve_mp;
    localparam int NP  = 2;
    localparam int DEP = 4;
    localparam int VL  = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        tk;
        logic        mp;
        logic [2:0]  cf;
    } ent_t;

    logic clk = 1'b0;
    logic rst, flush, res_ready;
    logic [1:0]   t_valid, t_valid_n, t_cmpr, t_comp;
    logic [3:0]   t_op;
    logic [5:0]   t_pcf;
    logic [127:0] t_pc, t_a, t_imm, t_pa;

    logic         ready_o, res_valid_o, res_taken_o, res_mispredict_o;
    logic [1:0]   result_valid_o, exc_valid_o;
    logic [127:0] result_o, exc_tval_o;
    logic [63:0]  res_pc_o, res_target_o;
    logic [2:0]   res_cf_o, count_o;

    logic         n_ready, n_resv, n_tk, n_mp;
    logic [1:0]   n_rv, n_exc;
    logic [127:0] n_res, n_tval;
    logic [63:0]  n_pc, n_tgt;
    logic [2:0]   n_cf, n_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_mp #(.NrPorts(NP), .Depth(DEP), .VLEN(VL), .RVC(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(ready_o),
        .valid_i(t_valid), .op_i(t_op), .pc_i(t_pc), .is_compressed_i(t_cmpr),
        .operand_a_i(t_a), .imm_i(t_imm), .comp_res_i(t_comp), .pred_cf_i(t_pcf),
        .pred_addr_i(t_pa), .result_valid_o(result_valid_o), .result_o(result_o),
        .exc_valid_o(exc_valid_o), .exc_tval_o(exc_tval_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready), .res_pc_o(res_pc_o), .res_target_o(res_target_o),
        .res_taken_o(res_taken_o), .res_mispredict_o(res_mispredict_o),
        .res_cf_o(res_cf_o), .count_o(count_o)
    );

    branch_resolve_mp #(.NrPorts(NP), .Depth(DEP), .VLEN(VL), .RVC(1'b0)) dut_norvc (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(n_ready),
        .valid_i(t_valid_n), .op_i(t_op), .pc_i(t_pc), .is_compressed_i(t_cmpr),
        .operand_a_i(t_a), .imm_i(t_imm), .comp_res_i(t_comp), .pred_cf_i(t_pcf),
        .pred_addr_i(t_pa), .result_valid_o(n_rv), .result_o(n_res),
        .exc_valid_o(n_exc), .exc_tval_o(n_tval), .res_valid_o(n_resv),
        .res_ready_i(1'b1), .res_pc_o(n_pc), .res_target_o(n_tgt),
        .res_taken_o(n_tk), .res_mispredict_o(n_mp), .res_cf_o(n_cf), .count_o(n_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t        mq[$];
    bit          started = 0;
    logic [1:0]  m_rv, m_exc, m_enq;
    logic [63:0] m_res [2];
    logic [63:0] m_tval [2];
    ent_t        m_ent [2];

    function automatic bit m_ready();
        int pend;
        pend = int'(m_enq[0]) + int'(m_enq[1]);
        return (DEP - mq.size() - pend) >= NP;
    endfunction

    function automatic void resolve(input int p, output logic [63:0] nxt, output ent_t e, output bit ex);
        logic [1:0]  o;
        logic [2:0]  pc3;
        logic [63:0] ppc, t;
        bit          tk, mp;
        o   = t_op[p*2 +: 2];
        pc3 = t_pcf[p*3 +: 3];
        ppc = t_pc[p*64 +: 64];
        nxt = ppc + (t_cmpr[p] ? 64'd2 : 64'd4);
        if (o == 2'b10) t = (t_a[p*64 +: 64] + t_imm[p*64 +: 64]) & ~64'd1;
        else            t = ppc + t_imm[p*64 +: 64];
        tk = (o == 2'b00) ? t_comp[p] : 1'b1;
        case (o)
            2'b00:   mp = (tk != (pc3 == 3'd1));
            2'b10:   mp = (pc3 == 3'd0) || (t != t_pa[p*64 +: 64]);
            default: mp = 1'b0;
        endcase
        ex    = tk && t[0];
        e.pc  = ppc;
        e.tgt = tk ? t : nxt;
        e.tk  = tk;
        e.mp  = mp;
        e.cf  = (o == 2'b00) ? 3'd1 : ((o == 2'b10) && mp && pc3 != 3'd4) ? 3'd3 : pc3;
    endfunction

    always @(posedge clk) begin : model
        bit          rdy, kill, ex;
        logic [63:0] nxt;
        ent_t        e;
        if (rst) begin
            mq.delete();
            started = 1;
        end else begin
            rdy = m_ready();
            if (flush) mq.delete();
            else begin
                if (mq.size() > 0 && res_ready) void'(mq.pop_front());
                for (int p = 0; p < NP; p++) if (m_enq[p]) mq.push_back(m_ent[p]);
            end
        end
        m_rv = '0; m_exc = '0; m_enq = '0;
        for (int p = 0; p < NP; p++) begin
            m_res[p] = '0; m_tval[p] = '0; m_ent[p] = '0;
        end
        kill = 0;
        if (!rst && !flush && rdy) begin
            for (int p = 0; p < NP; p++) begin
                if (t_valid[p] && t_op[p*2 +: 2] != 2'b11 && !kill) begin
                    resolve(p, nxt, e, ex);
                    m_rv[p]  = 1'b1;
                    m_res[p] = nxt;
                    if (ex) begin
                        m_exc[p]  = 1'b1;
                        m_tval[p] = e.pc;
                    end else begin
                        m_enq[p] = 1'b1;
                        m_ent[p] = e;
                    end
                    if (ex || e.mp) kill = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        ent_t h;
        if (started) begin
            h = '0;
            if (mq.size() > 0) h = mq[0];
            chk("ready", 64'(ready_o), 64'(m_ready()));
            chk("result_valid", 64'(result_valid_o), 64'(m_rv));
            chk("result0", result_o[63:0], m_res[0]);
            chk("result1", result_o[127:64], m_res[1]);
            chk("exc_valid", 64'(exc_valid_o), 64'(m_exc));
            chk("exc_tval0", exc_tval_o[63:0], m_tval[0]);
            chk("exc_tval1", exc_tval_o[127:64], m_tval[1]);
            chk("res_valid", 64'(res_valid_o), 64'(mq.size() > 0));
            chk("res_pc", res_pc_o, h.pc);
            chk("res_target", res_target_o, h.tgt);
            chk("res_taken", 64'(res_taken_o), 64'(h.tk));
            chk("res_mispredict", 64'(res_mispredict_o), 64'(h.mp));
            chk("res_cf", 64'(res_cf_o), 64'(h.cf));
            chk("count", 64'(count_o), 64'(mq.size()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        t_valid = '0; t_valid_n = '0; t_op = '0; t_pc = '0; t_cmpr = '0;
        t_a = '0; t_imm = '0; t_comp = '0; t_pcf = '0; t_pa = '0;
    endtask

    task automatic set_port(input int p, input logic [1:0] o, input logic [63:0] pcv,
                            input logic c, input logic [63:0] av, input logic [63:0] immv,
                            input logic cr, input logic [2:0] pcfv, input logic [63:0] pav);
        t_valid[p]       = 1'b1;
        t_op[p*2 +: 2]   = o;
        t_pc[p*64 +: 64] = pcv;
        t_cmpr[p]        = c;
        t_a[p*64 +: 64]  = av;
        t_imm[p*64 +: 64] = immv;
        t_comp[p]        = cr;
        t_pcf[p*3 +: 3]  = pcfv;
        t_pa[p*64 +: 64] = pav;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(ready_o), 64'd1);
    endtask

    task automatic drain(input int n);
        res_ready = 1'b1;
        repeat (n) tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
        clr();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_result_valid", 64'(result_valid_o), 64'd0);
        tick();

        // Taken branch predicted as no-CF
        wait_ready();
        set_port(0, 2'b00, 64'h1000, 0, 64'h0, 64'h20, 1, 3'd0, 64'h0);
        tick(); clr();
        chk("t1_rv", 64'(result_valid_o), 64'd1);
        chk("t1_result", result_o[63:0], 64'h1004);
        tick();
        chk("t1_head_target", res_target_o, 64'h1020);
        chk("t1_head_taken", 64'(res_taken_o), 64'd1);
        chk("t1_head_misp", 64'(res_mispredict_o), 64'd1);
        chk("t1_head_cf", 64'(res_cf_o), 64'd1);
        drain(1);

        // Correctly predicted JALR + JAL
        wait_ready();
        set_port(0, 2'b10, 64'h3000, 0, 64'h2001, 64'h0, 0, 3'd3, 64'h2000);
        set_port(1, 2'b01, 64'h3004, 0, 64'h0, 64'h100, 0, 3'd2, 64'h3104);
        tick(); clr();
        chk("t2_rv", 64'(result_valid_o), 64'd3);
        chk("t2_result1", result_o[127:64], 64'h3008);
        tick();
        chk("t2_count", 64'(count_o), 64'd2);
        chk("t2_head_target", res_target_o, 64'h2000);
        chk("t2_head_misp", 64'(res_mispredict_o), 64'd0);
        drain(2);

        // Mispredicted compressed branch squashes the younger JAL
        wait_ready();
        set_port(0, 2'b00, 64'h4000, 1, 64'h0, 64'h80, 0, 3'd1, 64'h4080);
        set_port(1, 2'b01, 64'h4002, 0, 64'h0, 64'h10, 0, 3'd2, 64'h4012);
        tick(); clr();
        chk("t3_rv", 64'(result_valid_o), 64'd1);
        chk("t3_result0", result_o[63:0], 64'h4002);
        tick();
        chk("t3_count", 64'(count_o), 64'd1);
        chk("t3_head_target", res_target_o, 64'h4002);
        drain(1);

        // Half-word target: legal with RVC, misaligned without
        wait_ready();
        set_port(0, 2'b01, 64'h100, 0, 64'h0, 64'h6, 0, 3'd2, 64'h106);
        t_valid_n = t_valid;
        tick(); clr();
        chk("t4_norvc_exc", 64'(n_exc), 64'd1);
        chk("t4_norvc_tval", n_tval[63:0], 64'h100);
        chk("t4_rvc_exc", 64'(exc_valid_o), 64'd0);
        tick();
        chk("t4_norvc_count", 64'(n_cnt), 64'd0);
        chk("t4_norvc_res_valid", 64'(n_resv), 64'd0);
        chk("t4_rvc_count", 64'(count_o), 64'd1);
        drain(1);

        // Reserved op is ignored; mispredicted return keeps its cf type
        wait_ready();
        set_port(0, 2'b11, 64'h5000, 0, 64'h0, 64'h0, 0, 3'd0, 64'h0);
        set_port(1, 2'b10, 64'h5004, 0, 64'h6000, 64'h10, 0, 3'd4, 64'h7000);
        tick(); clr();
        chk("t5_rv", 64'(result_valid_o), 64'd2);
        chk("t5_result1", result_o[127:64], 64'h5008);
        tick();
        chk("t5_head_cf", 64'(res_cf_o), 64'd4);
        chk("t5_head_target", res_target_o, 64'h6010);
        drain(1);

        // Fill towards full, then simultaneous push and pop
        wait_ready();
        set_port(0, 2'b01, 64'h8000, 0, 64'h0, 64'h40, 0, 3'd2, 64'h0);
        set_port(1, 2'b01, 64'h8004, 0, 64'h0, 64'h80, 0, 3'd2, 64'h0);
        tick(); clr();
        set_port(0, 2'b01, 64'h8008, 0, 64'h0, 64'h20, 0, 3'd2, 64'h0);
        tick(); clr();
        tick();
        chk("t6_count3", 64'(count_o), 64'd3);
        chk("t6_ready_full", 64'(ready_o), 64'd0);
        drain(1);
        chk("t6_ready_again", 64'(ready_o), 64'd1);
        set_port(0, 2'b01, 64'h8010, 0, 64'h0, 64'h4, 0, 3'd2, 64'h0);
        tick(); clr();
        drain(1);
        chk("t6_pushpop_count", 64'(count_o), 64'd2);

        // Flush with three queued entries and valid inputs
        wait_ready();
        set_port(0, 2'b01, 64'h9000, 0, 64'h0, 64'h8, 0, 3'd2, 64'h0);
        tick(); clr();
        tick();
        chk("t7_count3", 64'(count_o), 64'd3);
        flush = 1'b1;
        set_port(0, 2'b01, 64'h9100, 0, 64'h0, 64'h8, 0, 3'd2, 64'h0);
        set_port(1, 2'b01, 64'h9104, 0, 64'h0, 64'h8, 0, 3'd2, 64'h0);
        tick(); clr();
        flush = 1'b0;
        chk("t7_count0", 64'(count_o), 64'd0);
        chk("t7_res_valid", 64'(res_valid_o), 64'd0);
        chk("t7_rv", 64'(result_valid_o), 64'd0);

        // Not-taken branch after flush
        wait_ready();
        set_port(0, 2'b00, 64'hA000, 0, 64'h0, 64'h40, 0, 3'd0, 64'h0);
        tick(); clr();
        tick();
        chk("t8_head_target", res_target_o, 64'hA004);
        chk("t8_head_misp", 64'(res_mispredict_o), 64'd0);
        drain(1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
